// File: rtl/jtdsp16_pkg.sv
// Shared DSP16 definitions: ROM loader state encoding and default program ROM
// address width (the ROM itself is sized from the same constant).
package jtdsp16_pkg;

  localparam int JTDSP16_ROM_AW = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/jtdsp16_rom_loader.sv
// DSP16 program ROM loader: packs a little-endian byte stream into 16-bit words,
// writes them sequentially from address 0 and keeps a running 16-bit checksum.
module jtdsp16_rom_loader
  import jtdsp16_pkg::*;
#(
  parameter int AW    = JTDSP16_ROM_AW,
  parameter int WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic          prog_we,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum,
  output ldr_state_e    dbg_state_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  ldr_state_e    state_q;
  logic [7:0]    low_q;
  logic [AW-1:0] prog_addr_q;
  logic [15:0]   prog_data_q;
  logic          prog_we_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   checksum_q;
  logic          xfer;

  // Handshake: a byte moves only when byte_valid & byte_ready on a rising edge.
  // byte_ready depends on the registered state alone, so the source may hold
  // byte_valid high for as long as it likes without a combinational loop.
  assign byte_ready = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      low_q       <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_LOW;
            prog_addr_q <= '0;
            checksum_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_LOW: begin
          if (xfer) begin
            low_q   <= byte_in;
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (xfer) begin
            prog_data_q <= {byte_in, low_q};
            prog_we_q   <= 1'b1;
            state_q     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          prog_we_q  <= 1'b0;
          checksum_q <= checksum_q + prog_data_q;
          // Address saturates on the final word so DONE reports where loading ended.
          if (prog_addr_q == LAST_ADDR) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            prog_addr_q <= prog_addr_q + AW'(1);
            state_q     <= ST_LOW;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign prog_addr   = prog_addr_q;
  assign prog_data   = prog_data_q;
  assign prog_we     = prog_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign checksum    = checksum_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// Bench for jtdsp16_rom_loader: a 4-word instance for protocol corners and a
// default 4096-word instance for the full-image load.
module tb_jtdsp16_rom_loader;
  import jtdsp16_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-word instance
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [11:0] prog_addr;
  logic [15:0] prog_data;
  logic        prog_we, busy, done;
  logic [15:0] checksum;
  ldr_state_e  dbg_state;

  // default-size instance
  logic [7:0]  byte_in_b = '0;
  logic        byte_valid_b = 1'b0;
  logic        byte_ready_b;
  logic [11:0] prog_addr_b;
  logic [15:0] prog_data_b;
  logic        prog_we_b, busy_b, done_b;
  logic [15:0] checksum_b;
  ldr_state_e  dbg_state_b;

  jtdsp16_rom_loader #(.AW(12), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_we(prog_we), .busy(busy), .done(done), .checksum(checksum),
    .dbg_state_o(dbg_state)
  );

  jtdsp16_rom_loader dut_big (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in_b), .byte_valid(byte_valid_b),
    .byte_ready(byte_ready_b), .prog_addr(prog_addr_b), .prog_data(prog_data_b),
    .prog_we(prog_we_b), .busy(busy_b), .done(done_b), .checksum(checksum_b),
    .dbg_state_o(dbg_state_b)
  );

  // ---------------- monitors ----------------
  logic [27:0] got_q[$];
  int          we_cnt_b = 0;
  logic [11:0] last_addr_b = '0;

  always @(negedge clk) begin
    if (prog_we) got_q.push_back({prog_addr, prog_data});
    if (prog_we_b) begin
      we_cnt_b    = we_cnt_b + 1;
      last_addr_b = prog_addr_b;
    end
  end

  // ---------------- scoreboard ----------------
  logic [27:0] exp_q[$];
  logic [7:0]  stim_q[$];
  int          exp_total = 0;
  int          rd_idx = 0;
  logic [15:0] exp_sum;
  int          checks = 0;
  int          errors = 0;
  int          t_start, t_done;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [11:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/absent expected event", name);
  endtask

  // Reference model: word i = byte[2i] + 256*byte[2i+1], written at address i.
  task automatic build_expected();
    exp_sum = '0;
    for (int i = 0; i < stim_q.size() / 2; i++) begin
      int w;
      w = int'(stim_q[2*i]) + 256 * int'(stim_q[2*i+1]);
      exp_q.push_back({12'(i), 16'(w)});
      exp_total++;
      exp_sum = 16'((int'(exp_sum) + w) % 65536);
    end
  endtask

  task automatic compare_writes(input string name);
    logic [27:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        chk(name, 32'(got_q[rd_idx]), 32'(e));
        rd_idx++;
      end else begin
        fail_now({name, "_missing"});
      end
    end
    chk({name, "_count"}, got_q.size(), exp_total);
    rd_idx = got_q.size();
  endtask

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_valid_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("send_byte");
  endtask

  task automatic feed_stim(input int max_gap);
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], $urandom_range(max_gap, 0));
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    t_done = cyc;
    if (!done) fail_now("wait_done");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_we"}, prog_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, prog_addr, 0);
    chk({tag, "_data"}, prog_data, 0);
    chk({tag, "_sum"}, checksum, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    vecs[0] = '{8'h01, 8'h02, 12'h000, 16'h0201};
    vecs[1] = '{8'h03, 8'h04, 12'h001, 16'h0403};
    vecs[2] = '{8'h05, 8'h06, 12'h002, 16'h0605};
    vecs[3] = '{8'h07, 8'h08, 12'h003, 16'h0807};

    @(negedge clk);
    do_reset();
    check_reset_outputs("reset");

    // 1: back-to-back stream, table driven
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].lo, 0);
      send_byte(vecs[i].hi, 0);
    end
    byte_valid = 1'b0;
    wait_done(40);
    chk("t1_done_latency", t_done - t_start, 13);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({vecs[i].addr, vecs[i].data});
      exp_total++;
    end
    compare_writes("t1_write");
    chk("t1_checksum", checksum, 16'h1410);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 1);

    // 2: same bytes with random gaps and a long stall between low and high
    stim_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        byte_valid = 1'b0;
        n = got_q.size();
        repeat (6) @(negedge clk);
        chk("t2_stall_no_we", got_q.size(), n);
        chk("t2_stall_busy", busy, 1);
      end
      send_byte(stim_q[i], $urandom_range(3, 0));
    end
    byte_valid = 1'b0;
    wait_done(60);
    build_expected();
    compare_writes("t2_write");
    chk("t2_checksum", checksum, 16'h1410);

    // random data sessions against the model
    for (int s = 0; s < 3; s++) begin
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom_range(255, 0)));
      pulse_start();
      feed_stim(4);
      wait_done(80);
      build_expected();
      compare_writes("rand_write");
      chk("rand_checksum", checksum, exp_sum);
    end

    // 3: reset after three accepted bytes
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    byte_valid = 1'b0;
    exp_q.push_back({12'h000, 16'h0201});
    exp_total++;
    compare_writes("t3_partial");
    do_reset();
    check_reset_outputs("t3_rst");
    chk("t3_no_extra_write", got_q.size(), exp_total);
    stim_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pulse_start();
    feed_stim(2);
    wait_done(80);
    build_expected();
    compare_writes("t3_restart");
    chk("t3_checksum", checksum, exp_sum);

    // 4: start in HIGH ignored; restart from DONE clears state
    stim_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    pulse_start();
    send_byte(stim_q[0], 0);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_still_high", dbg_state, ST_HIGH);
    chk("t4_busy", busy, 1);
    for (int i = 1; i < 8; i++) send_byte(stim_q[i], $urandom_range(2, 0));
    byte_valid = 1'b0;
    wait_done(80);
    build_expected();
    compare_writes("t4_write");
    chk("t4_checksum", checksum, exp_sum);
    pulse_start();
    chk("t4_restart_done", done, 0);
    chk("t4_restart_sum", checksum, 0);
    chk("t4_restart_addr", prog_addr, 0);
    chk("t4_restart_busy", busy, 1);
    feed_stim(1);
    wait_done(80);
    build_expected();
    compare_writes("t4_rewrite");
    chk("t4_rewrite_sum", checksum, exp_sum);

    // 6: byte_valid held in IDLE and DONE is never consumed
    do_reset();
    byte_in = 8'hAA;
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_idle_ready", byte_ready, 0);
    end
    stim_q = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    pulse_start();
    feed_stim(0);
    wait_done(60);
    build_expected();
    compare_writes("t6_write");
    n = got_q.size();
    byte_in = 8'h5A;
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_done_ready", byte_ready, 0);
    end
    byte_valid = 1'b0;
    chk("t6_done_no_we", got_q.size(), n);
    chk("t6_done_held", done, 1);

    // 5: full 4096-word image of FFFF
    do_reset();
    n = we_cnt_b;
    byte_in_b = 8'hFF;
    byte_valid_b = 1'b1;
    pulse_start();
    for (int i = 0; i < 13000 && !done_b; i++) @(negedge clk);
    if (!done_b) fail_now("t5_wait_done");
    chk("t5_latency", cyc - t_start, 4096 * 3 + 1);
    chk("t5_write_count", we_cnt_b - n, 4096);
    chk("t5_last_addr", last_addr_b, 12'hFFF);
    chk("t5_checksum", checksum_b, 16'hF000);
    repeat (5) @(negedge clk);
    chk("t5_addr_hold", prog_addr_b, 12'hFFF);
    chk("t5_done_hold", done_b, 1);
    chk("t5_ready_low", byte_ready_b, 0);
    chk("t5_no_more_we", we_cnt_b - n, 4096);
    byte_valid_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
